// File: rtl/gpio_cfg_pkg.sv
// Shared constants, FSM encoding and reset-word helper for the GPIO config shadow.
package gpio_cfg_pkg;

  localparam int IO_CTRL_BITS = 13;
  localparam int OEB          = 1;
  localparam int INP_DIS      = 3;
  localparam int CNT_W        = 9;

  localparam logic [IO_CTRL_BITS-1:0] CFG_BIDIR = 13'h1803;
  localparam logic [IO_CTRL_BITS-1:0] CFG_INPUT = 13'h0403;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01,
    ST_COMMIT = 2'b10
  } state_t;

  function automatic logic [IO_CTRL_BITS-1:0] reset_word(
    input int                      pad,
    input int                      num_bidir,
    input logic [IO_CTRL_BITS-1:0] bidir_word,
    input logic [IO_CTRL_BITS-1:0] input_word
  );
    return (pad < num_bidir) ? bidir_word : input_word;
  endfunction

endpackage

// File: rtl/gpio_cfg_sampler.sv
// Registers the serial chain pins in the clk domain and decodes rise/load/abort events.
module gpio_cfg_sampler (
  input  logic clk,
  input  logic resetn,
  input  logic serial_clock,
  input  logic serial_resetn,
  input  logic serial_data_in,
  output logic data_q,
  output logic rise,
  output logic load,
  output logic abort
);

  logic clock_q;
  logic clock_qq;
  logic resetn_q;
  logic resetn_qq;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clock_q   <= 1'b0;
      clock_qq  <= 1'b0;
      resetn_q  <= 1'b0;
      resetn_qq <= 1'b0;
      data_q    <= 1'b0;
    end else begin
      clock_q   <= serial_clock;
      clock_qq  <= clock_q;
      resetn_q  <= serial_resetn;
      resetn_qq <= resetn_q;
      data_q    <= serial_data_in;
    end
  end

  // Load is the chain reset falling while the chain clock is high; abort is
  // the chain reset low with the clock low. Both need resetn_q low, rise needs
  // it high, so the three events never coincide.
  assign rise  = clock_q & ~clock_qq & resetn_q;
  assign load  = ~resetn_q & resetn_qq & clock_q;
  assign abort = ~resetn_q & ~clock_q;

endmodule

// File: rtl/gpio_cfg_shadow.sv
// Shadow register file for one GPIO config chain: shift, atomic commit, readback.
module gpio_cfg_shadow
  import gpio_cfg_pkg::*;
#(
  parameter int                      NUM_PADS      = 19,
  parameter int                      NUM_BIDIR     = 2,
  parameter logic [IO_CTRL_BITS-1:0] CFG_BIDIR_VAL = CFG_BIDIR,
  parameter logic [IO_CTRL_BITS-1:0] CFG_INPUT_VAL = CFG_INPUT
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             serial_clock,
  input  logic                             serial_resetn,
  input  logic                             serial_data_in,
  output logic [NUM_PADS*IO_CTRL_BITS-1:0] cfg_flat,
  output logic [NUM_PADS-1:0]              pad_oeb,
  output logic [NUM_PADS-1:0]              pad_inp_dis,
  input  logic [4:0]                       rd_idx,
  output logic [IO_CTRL_BITS-1:0]          rd_cfg,
  output logic                             cfg_update,
  output logic                             busy,
  output logic                             err_len,
  output state_t                           fsm_state
);

  localparam int               L     = NUM_PADS * IO_CTRL_BITS;
  localparam logic [CNT_W-1:0] L_CNT = CNT_W'(L);

  logic data_q;
  logic rise;
  logic load;
  logic abort;

  gpio_cfg_sampler u_sampler (
    .clk            (clk),
    .resetn         (resetn),
    .serial_clock   (serial_clock),
    .serial_resetn  (serial_resetn),
    .serial_data_in (serial_data_in),
    .data_q         (data_q),
    .rise           (rise),
    .load           (load),
    .abort          (abort)
  );

  logic [L-1:0]            chain;
  logic [CNT_W-1:0]        bit_cnt;
  logic [IO_CTRL_BITS-1:0] cfg_q [NUM_PADS];
  state_t                  state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chain      <= '0;
      bit_cnt    <= '0;
      state      <= ST_IDLE;
      rd_cfg     <= '0;
      cfg_update <= 1'b0;
      err_len    <= 1'b0;
      for (int k = 0; k < NUM_PADS; k++) begin
        cfg_q[k] <= reset_word(k, NUM_BIDIR, CFG_BIDIR_VAL, CFG_INPUT_VAL);
      end
    end else begin
      cfg_update <= 1'b0;

      if (int'(rd_idx) < NUM_PADS) rd_cfg <= cfg_q[rd_idx];
      else                         rd_cfg <= '0;

      case (state)
        ST_IDLE: begin
          if (rise) begin
            chain <= {chain[L-2:0], data_q};
            if (bit_cnt != '1) bit_cnt <= bit_cnt + 1'b1;
            state <= ST_SHIFT;
          end else if (load) begin
            state <= ST_COMMIT;
          end
        end
        ST_SHIFT: begin
          if (rise) begin
            chain <= {chain[L-2:0], data_q};
            if (bit_cnt != '1) bit_cnt <= bit_cnt + 1'b1;
          end else if (load) begin
            state <= ST_COMMIT;
          end else if (abort) begin
            chain   <= '0;
            bit_cnt <= '0;
            state   <= ST_IDLE;
          end
        end
        ST_COMMIT: begin
          if (bit_cnt == L_CNT) begin
            for (int k = 0; k < NUM_PADS; k++) begin
              cfg_q[k] <= chain[k*IO_CTRL_BITS +: IO_CTRL_BITS];
            end
            cfg_update <= 1'b1;
            err_len    <= 1'b0;
          end else begin
            err_len <= 1'b1;
          end
          // The chain restarts empty; a rise landing here becomes its first bit.
          if (rise) begin
            chain   <= {{(L-1){1'b0}}, data_q};
            bit_cnt <= CNT_W'(1);
          end else begin
            chain   <= '0;
            bit_cnt <= '0;
          end
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_PADS; k++) begin : g_pad
    assign cfg_flat[k*IO_CTRL_BITS +: IO_CTRL_BITS] = cfg_q[k];
    assign pad_oeb[k]     = cfg_q[k][OEB];
    assign pad_inp_dis[k] = cfg_q[k][INP_DIS];
  end

  assign busy      = (state != ST_IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_gpio_cfg_shadow.sv
// Randomized bench for gpio_cfg_shadow against a bit-stream reference model.
module tb_gpio_cfg_shadow;
  import gpio_cfg_pkg::*;

  localparam int NP = 19;
  localparam int B  = IO_CTRL_BITS;
  localparam int L  = NP * B;

  logic          clk = 1'b0;
  logic          resetn;
  logic          serial_clock;
  logic          serial_resetn;
  logic          serial_data_in;
  logic [4:0]    rd_idx;
  logic [L-1:0]  cfg_flat;
  logic [NP-1:0] pad_oeb;
  logic [NP-1:0] pad_inp_dis;
  logic [B-1:0]  rd_cfg;
  logic          cfg_update;
  logic          busy;
  logic          err_len;
  state_t        fsm_state;

  gpio_cfg_shadow #(.NUM_PADS(NP), .NUM_BIDIR(2)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .serial_clock   (serial_clock),
    .serial_resetn  (serial_resetn),
    .serial_data_in (serial_data_in),
    .cfg_flat       (cfg_flat),
    .pad_oeb        (pad_oeb),
    .pad_inp_dis    (pad_inp_dis),
    .rd_idx         (rd_idx),
    .rd_cfg         (rd_cfg),
    .cfg_update     (cfg_update),
    .busy           (busy),
    .err_len        (err_len),
    .fsm_state      (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_pass   = 0;
  logic [B-1:0] exp_cfg [NP];
  logic [B-1:0] stim    [NP];
  logic         exp_err;
  logic         bit_q [$];
  logic [B-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NP; k++) exp_cfg[k] = (k < 2) ? 13'h1803 : 13'h0403;
    exp_err = 1'b0;
  endtask

  task automatic fill_stim(input bit pattern);
    for (int k = 0; k < NP; k++) stim[k] = pattern ? B'(k) : B'($urandom_range(0, 8191));
  endtask

  // driver: one chain clock period with random low/high lengths
  task automatic send_bit(input logic d);
    serial_data_in = d;
    serial_clock   = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    serial_clock = 1'b1;
    repeat ($urandom_range(1, 10)) @(negedge clk);
    bit_q.push_back(d);
  endtask

  // Sends pad NP-1 first, each word MSB first; bits past L are random.
  task automatic send_stream(input int n);
    logic d;
    bit_q.delete();
    serial_clock  = 1'b0;
    serial_resetn = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i < L) d = stim[NP-1-i/B][B-1-i%B];
      else       d = 1'($urandom_range(0, 1));
      send_bit(d);
    end
  endtask

  task automatic do_load(input string tag);
    int           pulses;
    int           n;
    logic [B-1:0] w;
    pulses = 0;
    n = bit_q.size();
    check({tag, "_busy_pre"}, 32'(busy), 32'(n > 0));
    check({tag, "_state_pre"}, 32'(fsm_state), (n > 0) ? 32'(ST_SHIFT) : 32'(ST_IDLE));
    serial_resetn = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (cfg_update) pulses++;
    end
    serial_clock = 1'b0;
    repeat (2) @(negedge clk);
    serial_resetn = 1'b1;
    @(negedge clk);
    if (n == L) begin
      for (int k = 0; k < NP; k++) begin
        w = '0;
        for (int j = 0; j < B; j++) w[j] = bit_q[(NP-1-k)*B + (B-1-j)];
        exp_cfg[k] = w;
      end
      exp_err = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
    check({tag, "_pulses"}, 32'(pulses), (n == L) ? 32'd1 : 32'd0);
    check({tag, "_err_len"}, 32'(err_len), 32'(exp_err));
    check({tag, "_busy_post"}, 32'(busy), 32'd0);
  endtask

  task automatic check_cfg(input string tag);
    logic [NP-1:0] oeb;
    logic [NP-1:0] idis;
    int            idx;
    for (int k = 0; k < NP; k++) begin
      check($sformatf("%s_cfg%0d", tag, k), 32'(cfg_flat[k*B +: B]), 32'(exp_cfg[k]));
      oeb[k]  = exp_cfg[k][1];
      idis[k] = exp_cfg[k][3];
    end
    check({tag, "_oeb"}, 32'(pad_oeb), 32'(oeb));
    check({tag, "_inp_dis"}, 32'(pad_inp_dis), 32'(idis));
    // scoreboard for readback
    for (int r = 0; r < 6; r++) begin
      idx = (r == 0) ? 7 : $urandom_range(0, 31);
      exp_q.push_back((idx < NP) ? exp_cfg[idx] : '0);
      rd_idx = 5'(idx);
      @(negedge clk);
      check($sformatf("%s_rd%0d", tag, idx), 32'(rd_cfg), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    resetn         = 1'b0;
    serial_clock   = 1'b0;
    serial_resetn  = 1'b0;
    serial_data_in = 1'b0;
    rd_idx         = 5'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check("t1_err_len_in_reset", 32'(err_len), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("t1_rd0", 32'(rd_cfg), 32'h1803);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_update", 32'(cfg_update), 32'd0);
    check("t1_state", 32'(fsm_state), 32'(ST_IDLE));
    rd_idx = 5'd5;
    @(negedge clk);
    check("t1_rd5", 32'(rd_cfg), 32'h0403);
    check_cfg("t1");

    fill_stim(1'b1);
    send_stream(L);
    do_load("t2");
    check_cfg("t2");

    fill_stim(1'b0);
    send_stream(L - 1);
    do_load("t3_short");
    check_cfg("t3_short");
    send_stream(L);
    do_load("t3_good");
    check_cfg("t3_good");

    fill_stim(1'b0);
    send_stream(100);
    serial_clock = 1'b0;
    repeat (2) @(negedge clk);
    serial_resetn = 1'b0;
    begin
      int pulses;
      pulses = 0;
      repeat (6) begin
        @(negedge clk);
        if (cfg_update) pulses++;
      end
      check("t4_pulses", 32'(pulses), 32'd0);
      check("t4_busy", 32'(busy), 32'd0);
      check("t4_state", 32'(fsm_state), 32'(ST_IDLE));
    end
    serial_resetn = 1'b1;
    check_cfg("t4_abort");
    send_stream(L);
    do_load("t4_good");
    check_cfg("t4_good");

    fill_stim(1'b0);
    send_stream(L + 1);
    do_load("t6_long");
    check_cfg("t6_long");

    // load with no chain edges at all
    serial_resetn = 1'b0;
    serial_clock  = 1'b1;
    repeat (2) @(negedge clk);
    bit_q.delete();
    serial_resetn = 1'b1;
    repeat (2) @(negedge clk);
    do_load("zero_edges");
    check_cfg("zero_edges");

    fill_stim(1'b0);
    send_stream(50);
    resetn        = 1'b0;
    serial_clock  = 1'b0;
    serial_resetn = 1'b0;
    model_reset();
    @(negedge clk);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_update", 32'(cfg_update), 32'd0);
    check("t5_err_len", 32'(err_len), 32'd0);
    for (int k = 0; k < NP; k++)
      check($sformatf("t5_cfg%0d", k), 32'(cfg_flat[k*B +: B]), 32'(exp_cfg[k]));
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_update_after", 32'(cfg_update), 32'd0);
    check_cfg("t5");

    for (int t = 0; t < 3; t++) begin
      fill_stim(1'b0);
      send_stream(L);
      do_load($sformatf("rand%0d", t));
      check_cfg($sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
